moo_ccm_tag: RTL and testbench
==============================

MOO_CCM_TAG -- requirements
Module: moo_ccm_tag

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; no other clock or async input.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- clr_core  in  1  synchronous core clear; same effect as rst
- tag_start  in  1  pulse; begin a tag operation (IDLE only)
- tag_dec  in  1  0 = emit encrypted tag, 1 = verify received tag
- tag_mp  in  3  CCM M' field; tag bytes M = 2*tag_mp+2; 0 reserved
- ccm_d  in  128  final CBC-MAC value T
- ecb_do  in  128  keystream block S0 = E(K, A0)
- ecb_vld  in  1  ecb_do valid, single-cycle pulse
- tag_do  out  32  encrypted tag word
- tag_do_vld  out  1  tag_do valid
- tag_do_rdy  in  1  consumer accepts tag_do
- tag_di  in  32  received tag word
- tag_di_vld  in  1  tag_di valid
- tag_di_rdy  out  1  block accepts tag_di
- tag_busy  out  1  high when state != IDLE
- tag_done  out  1  one-cycle completion pulse
- tag_ok  out  1  result; held until next accepted tag_start

Function
REQ-003 SHALL implement states IDLE, WAIT_S0, ENC_OUT, DEC_IN, DONE.
REQ-004 IDLE + tag_start: latch ccm_d, tag_dec, tag_mp; clear word counter and mismatch flag; clear tag_ok; go to WAIT_S0 next cycle.
REQ-005 IDLE + tag_start with tag_mp=0: go directly to DONE; tag_ok=0; no data transfer.
REQ-006 tag_start outside IDLE SHALL be ignored.
REQ-007 WAIT_S0 + ecb_vld: register U = T ^ ecb_do; go to ENC_OUT (tag_dec=0) or DEC_IN (tag_dec=1). ecb_vld in any other state SHALL be ignored.
REQ-008 Word count N = ceil(M/4): M' 1..7 -> N = 1,2,2,3,3,4,4.
REQ-009 Word k (0..N-1) = U[127-32k -: 32]; byte j of the tag (j=0 is U[127:120]) is valid iff j < M.
REQ-010 ENC_OUT: tag_do_vld=1; tag_do = word k with invalid bytes forced to 0x00; hold tag_do stable until tag_do_rdy; on vld&rdy, k increments; transfer of word N-1 goes to DONE.
REQ-011 tag_do_vld SHALL be 0 and tag_do SHALL be 0 outside ENC_OUT.
REQ-012 DEC_IN: tag_di_rdy=1; on tag_di_vld, compare valid bytes of tag_di against word k and ignore invalid bytes; OR any difference into the mismatch flag; k increments; word N-1 goes to DONE.
REQ-013 tag_di_rdy SHALL be 0 outside DEC_IN.
REQ-014 DONE: tag_done=1 for exactly one cycle; tag_ok = 1 for encrypt; !mismatch for decrypt; 0 for the reserved M'; then go to IDLE.
REQ-015 tag_ok SHALL change only on entering DONE or on an accepted tag_start.
REQ-016 Minimum latency: start to done = 3 + N cycles when ecb_vld arrives on the first WAIT_S0 cycle and the handshake never stalls.
REQ-017 Latched T, mode and M' SHALL NOT change during an operation, even if ccm_d, tag_dec or tag_mp change.

Reset
REQ-018 rst or clr_core SHALL force IDLE and zero the latched T, U, counter and mismatch flag.
REQ-019 After rst or clr_core, all outputs SHALL be 0: tag_do, tag_do_vld, tag_di_rdy, tag_busy, tag_done, tag_ok.
REQ-020 rst/clr_core SHALL take priority over every other input in the same cycle, including mid-operation; no tag_done pulse follows an aborted operation.

Verification
REQ-021 Encrypt, M'=7, T=0, S0=0x00112233_44556677_8899AABB_CCDDEEFF, rdy always 1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles; tag_done with tag_ok=1.
REQ-022 Encrypt, M'=2 (M=6), T=all-ones, S0=0 -> words FFFFFFFF, FFFF0000; rdy low for 3 cycles on word 1 -> word 1 held stable throughout.
REQ-023 Decrypt, M'=1 (M=4), U=0xDEADBEEF in the top word, tag_di=DEADBEEF -> tag_ok=1; repeat with DEADBEEE -> tag_ok=0.
REQ-024 Decrypt, M'=2, correct first 6 bytes, trailing 2 bytes of word 1 = 0xA5A5 -> tag_ok=1 (invalid bytes ignored).
REQ-025 tag_mp=0 start -> DONE on the next cycle; tag_done=1, tag_ok=0; tag_do_vld and tag_di_rdy never asserted.
REQ-026 clr_core asserted in ENC_OUT after word 0 -> next cycle IDLE, all outputs 0, no tag_done; a new start with ecb_vld 0 cycles later completes normally.

Source files
------------

// File: rtl/moo_ccm_tag.sv
// CCM tag stage: forms U = T ^ S0, then streams the encrypted tag out (encrypt)
// or compares a received tag against it (decrypt), honouring the M-byte tag length.
module moo_ccm_tag (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_core,
  input  logic         tag_start,
  input  logic         tag_dec,
  input  logic [2:0]   tag_mp,
  input  logic [127:0] ccm_d,
  input  logic [127:0] ecb_do,
  input  logic         ecb_vld,
  output logic [31:0]  tag_do,
  output logic         tag_do_vld,
  input  logic         tag_do_rdy,
  input  logic [31:0]  tag_di,
  input  logic         tag_di_vld,
  output logic         tag_di_rdy,
  output logic         tag_busy,
  output logic         tag_done,
  output logic         tag_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_S0,
    S_ENC_OUT,
    S_DEC_IN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   t_q, t_d;
  logic [127:0]   u_q, u_d;
  logic           dec_q, dec_d;
  logic [2:0]     mp_q, mp_d;
  logic [1:0]     k_q, k_d;
  logic           mis_q, mis_d;
  logic           ok_q, ok_d;

  logic [31:0]    word;
  logic [31:0]    mask;
  logic [4:0]     m_bytes;
  logic [1:0]     last_k;
  logic           diff;

  // Tag length M = 2*M'+2 bytes; the last word index ceil(M/4)-1 reduces to M'>>1.
  assign m_bytes = {1'b0, mp_q, 1'b0} + 5'd2;
  assign last_k  = mp_q[2:1];

  always_comb begin
    case (k_q)
      2'd0:    word = u_q[127:96];
      2'd1:    word = u_q[95:64];
      2'd2:    word = u_q[63:32];
      default: word = u_q[31:0];
    endcase
  end

  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if ((5'({k_q, 2'b00}) + 5'(b)) < m_bytes) mask[31-8*b -: 8] = 8'hFF;
    end
  end

  assign diff = |((tag_di ^ word) & mask);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    u_d     = u_q;
    dec_d   = dec_q;
    mp_d    = mp_q;
    k_d     = k_q;
    mis_d   = mis_q;
    ok_d    = ok_q;
    case (state_q)
      S_IDLE: begin
        if (tag_start) begin
          t_d     = ccm_d;
          dec_d   = tag_dec;
          mp_d    = tag_mp;
          k_d     = '0;
          mis_d   = 1'b0;
          ok_d    = 1'b0;
          state_d = (tag_mp == 3'd0) ? S_DONE : S_WAIT_S0;
        end
      end
      S_WAIT_S0: begin
        if (ecb_vld) begin
          u_d     = t_q ^ ecb_do;
          state_d = dec_q ? S_DEC_IN : S_ENC_OUT;
        end
      end
      S_ENC_OUT: begin
        if (tag_do_rdy) begin
          k_d = k_q + 2'd1;
          if (k_q == last_k) begin
            ok_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DEC_IN: begin
        if (tag_di_vld) begin
          k_d   = k_q + 2'd1;
          mis_d = mis_q | diff;
          // Result is registered on the DONE transition so it is valid alongside tag_done.
          if (k_q == last_k) begin
            ok_d    = ~(mis_q | diff);
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_core) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      u_q     <= '0;
      dec_q   <= 1'b0;
      mp_q    <= '0;
      k_q     <= '0;
      mis_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      u_q     <= u_d;
      dec_q   <= dec_d;
      mp_q    <= mp_d;
      k_q     <= k_d;
      mis_q   <= mis_d;
      ok_q    <= ok_d;
    end
  end

  assign tag_do_vld = (state_q == S_ENC_OUT);
  assign tag_do     = (state_q == S_ENC_OUT) ? (word & mask) : '0;
  assign tag_di_rdy = (state_q == S_DEC_IN);
  assign tag_busy   = (state_q != S_IDLE);
  assign tag_done   = (state_q == S_DONE);
  assign tag_ok     = ok_q;

endmodule

// File: tb/tb_moo_ccm_tag.sv
// Self-checking bench for moo_ccm_tag: fixed vector table, abort sequences and
// randomized operations checked against a byte-level reference model.
module tb_moo_ccm_tag;

  logic         clk = 1'b0;
  logic         rst, clr_core, tag_start, tag_dec;
  logic [2:0]   tag_mp;
  logic [127:0] ccm_d, ecb_do;
  logic         ecb_vld;
  logic [31:0]  tag_do;
  logic         tag_do_vld, tag_do_rdy;
  logic [31:0]  tag_di;
  logic         tag_di_vld, tag_di_rdy;
  logic         tag_busy, tag_done, tag_ok;

  int n_chk  = 0;
  int n_fail = 0;

  moo_ccm_tag dut (
    .clk        (clk),
    .rst        (rst),
    .clr_core   (clr_core),
    .tag_start  (tag_start),
    .tag_dec    (tag_dec),
    .tag_mp     (tag_mp),
    .ccm_d      (ccm_d),
    .ecb_do     (ecb_do),
    .ecb_vld    (ecb_vld),
    .tag_do     (tag_do),
    .tag_do_vld (tag_do_vld),
    .tag_do_rdy (tag_do_rdy),
    .tag_di     (tag_di),
    .tag_di_vld (tag_di_vld),
    .tag_di_rdy (tag_di_rdy),
    .tag_busy   (tag_busy),
    .tag_done   (tag_done),
    .tag_ok     (tag_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           dec;
    logic [2:0]   mp;
    logic [127:0] t;
    logic [127:0] s0;
    logic [127:0] di;
    logic [127:0] exw;
    bit           ok;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: tag byte j is valid iff j < 2*M'+2; output keeps valid bytes of
  // T^S0 and zeroes the rest; verify passes iff every valid received byte matches.
  function automatic void model(input logic [127:0] t, input logic [127:0] s0,
                                input logic [2:0] mp, input logic [127:0] di,
                                output logic [127:0] exw, output bit okd);
    logic [127:0] u;
    int m;
    u   = t ^ s0;
    m   = 2 * int'(mp) + 2;
    exw = '0;
    okd = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (j < m) begin
        exw[127-8*j -: 8] = u[127-8*j -: 8];
        if (di[127-8*j -: 8] != u[127-8*j -: 8]) okd = 1'b0;
      end
    end
  endfunction

  task automatic idle_inputs();
    tag_start  = 1'b0;
    ecb_vld    = 1'b0;
    tag_do_rdy = 1'b0;
    tag_di_vld = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_do"},      128'(tag_do),     128'(0));
    chk({nm, "_do_vld"},  128'(tag_do_vld), 128'(0));
    chk({nm, "_di_rdy"},  128'(tag_di_rdy), 128'(0));
    chk({nm, "_busy"},    128'(tag_busy),   128'(0));
    chk({nm, "_done"},    128'(tag_done),   128'(0));
    chk({nm, "_ok"},      128'(tag_ok),     128'(0));
  endtask

  task automatic op(input bit dec, input logic [2:0] mp, input logic [127:0] t,
                    input logic [127:0] s0, input logic [127:0] di,
                    input logic [127:0] exw, input bit exok, input int delay,
                    input bit rnd, input int hold1);
    int n, k, steps, guard, held;
    bit xfer;
    n     = (2 * int'(mp) + 5) / 4;
    steps = 0;
    held  = 0;
    tag_start = 1'b1;
    tag_dec   = dec;
    tag_mp    = mp;
    ccm_d     = t;
    step(); steps++;
    // Latched parameters must survive input changes during the operation.
    tag_start = 1'b0;
    ccm_d     = r128();
    tag_dec   = ~dec;
    tag_mp    = 3'($urandom);
    chk("start_busy", 128'(tag_busy), 128'(1));
    if (mp == 3'd0) begin
      chk("rsv_done",   128'(tag_done),   128'(1));
      chk("rsv_ok",     128'(tag_ok),     128'(0));
      chk("rsv_do_vld", 128'(tag_do_vld), 128'(0));
      chk("rsv_di_rdy", 128'(tag_di_rdy), 128'(0));
      step();
      chk("rsv_idle", 128'(tag_busy), 128'(0));
      chk("rsv_done_clr", 128'(tag_done), 128'(0));
      chk("rsv_ok_hold", 128'(tag_ok), 128'(0));
      return;
    end
    chk("start_ok_clr", 128'(tag_ok), 128'(0));
    for (int d = 0; d < delay; d++) begin
      chk("wait_done",   128'(tag_done),   128'(0));
      chk("wait_do_vld", 128'(tag_do_vld), 128'(0));
      chk("wait_di_rdy", 128'(tag_di_rdy), 128'(0));
      tag_start = rnd ? 1'($urandom) : 1'b0;
      step(); steps++;
    end
    tag_start = 1'b0;
    ecb_do    = s0;
    ecb_vld   = 1'b1;
    step(); steps++;
    k = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      if (dec) begin
        tag_di_vld = rnd ? 1'($urandom) : 1'b1;
        tag_di     = tag_di_vld ? di[127-32*k -: 32] : $urandom;
        chk("dec_di_rdy", 128'(tag_di_rdy), 128'(1));
        chk("dec_do_vld", 128'(tag_do_vld), 128'(0));
        chk("dec_do",     128'(tag_do),     128'(0));
        xfer = tag_di_vld;
      end else begin
        if (k == 1 && held < hold1) begin
          tag_do_rdy = 1'b0;
          held++;
        end else begin
          tag_do_rdy = rnd ? 1'($urandom) : 1'b1;
        end
        chk("enc_do_vld", 128'(tag_do_vld), 128'(1));
        chk("enc_word",   128'(tag_do),     128'(exw[127-32*k -: 32]));
        chk("enc_di_rdy", 128'(tag_di_rdy), 128'(0));
        xfer = tag_do_rdy;
      end
      chk("xfer_done", 128'(tag_done), 128'(0));
      ecb_vld   = rnd ? 1'($urandom) : 1'b0;
      ecb_do    = r128();
      tag_start = rnd ? 1'($urandom) : 1'b0;
      step(); steps++; guard++;
      if (xfer) k++;
    end
    if (guard >= 200) chk("xfer_timeout", 128'(guard), 128'(0));
    tag_do_rdy = 1'b0;
    tag_di_vld = 1'b0;
    ecb_vld    = 1'b0;
    tag_start  = rnd ? 1'($urandom) : 1'b0;
    chk("done_pulse",  128'(tag_done),   128'(1));
    chk("done_ok",     128'(tag_ok),     128'(exok));
    chk("done_do_vld", 128'(tag_do_vld), 128'(0));
    chk("done_busy",   128'(tag_busy),   128'(1));
    // Done appears in the (N+3)th cycle counting the start cycle as the first.
    if (delay == 0 && !rnd && hold1 == 0) chk("latency", 128'(steps), 128'(n + 2));
    step();
    tag_start = 1'b0;
    chk("after_done",  128'(tag_done), 128'(0));
    chk("after_busy",  128'(tag_busy), 128'(0));
    chk("after_ok",    128'(tag_ok),   128'(exok));
    if (tag_busy) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] t, s0, di, exw, u;
    bit okd, dec;
    logic [2:0] mp;

    tbl[0]  = '{1'b0, 3'd7, 128'h0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h0,
                128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1};
    tbl[1]  = '{1'b0, 3'd2, {128{1'b1}}, 128'h0, 128'h0,
                128'hFFFFFFFF_FFFF0000_00000000_00000000, 1'b1};
    tbl[2]  = '{1'b1, 3'd1, 128'hDEADBEEF_00000000_00000000_00000000, 128'h0,
                128'hDEADBEEF_00000000_00000000_00000000, 128'h0, 1'b1};
    tbl[3]  = '{1'b1, 3'd1, 128'hDEADBEEF_00000000_00000000_00000000, 128'h0,
                128'hDEADBEEE_00000000_00000000_00000000, 128'h0, 1'b0};
    tbl[4]  = '{1'b1, 3'd2, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'h01234567_89ABA5A5_00000000_00000000, 128'h0, 1'b1};
    tbl[5]  = '{1'b1, 3'd2, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'h01234567_89AAA5A5_00000000_00000000, 128'h0, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 128'h0, 128'h0, 128'h0, 128'h0, 1'b0};
    tbl[7]  = '{1'b0, 3'd3, 128'h11111111_22222222_33333333_44444444,
                128'hFFFFFFFF_00000000_F0F0F0F0_0F0F0F0F, 128'h0,
                128'hEEEEEEEE_22222222_00000000_00000000, 1'b1};
    tbl[8]  = '{1'b0, 3'd4, 128'h11111111_22222222_33333333_44444444,
                128'hFFFFFFFF_00000000_F0F0F0F0_0F0F0F0F, 128'h0,
                128'hEEEEEEEE_22222222_C3C30000_00000000, 1'b1};
    tbl[9]  = '{1'b1, 3'd6, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'h01234567_89ABCDEF_FEDCBA98_7654FFFF, 128'h0, 1'b1};
    tbl[10] = '{1'b1, 3'd5, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'h01234567_89ABCDEF_FEDCBA99_00000000, 128'h0, 1'b0};

    rst = 1'b1; clr_core = 1'b0; tag_dec = 1'b0; tag_mp = '0;
    ccm_d = '0; ecb_do = '0; tag_di = '0;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < 11; i++) begin
      op(tbl[i].dec, tbl[i].mp, tbl[i].t, tbl[i].s0, tbl[i].di, tbl[i].exw,
         tbl[i].ok, 0, 1'b0, (i == 1) ? 3 : 0);
    end

    // clr_core while idle clears a held tag_ok.
    op(tbl[0].dec, tbl[0].mp, tbl[0].t, tbl[0].s0, tbl[0].di, tbl[0].exw, 1'b1, 0, 1'b0, 0);
    clr_core = 1'b1;
    step();
    clr_core = 1'b0;
    chk_zero("clr_idle");

    // Abort in ENC_OUT after word 0, with competing inputs in the same cycle.
    tag_start = 1'b1; tag_dec = 1'b0; tag_mp = 3'd7; ccm_d = tbl[0].t;
    step();
    tag_start = 1'b0; ecb_do = tbl[0].s0; ecb_vld = 1'b1;
    step();
    ecb_vld = 1'b0; tag_do_rdy = 1'b1;
    step();
    chk("abort_word1", 128'(tag_do), 128'(32'h44556677));
    clr_core = 1'b1; tag_start = 1'b1; ecb_vld = 1'b1;
    step();
    clr_core = 1'b0;
    idle_inputs();
    chk_zero("abort_enc");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 128'(tag_done), 128'(0));
    end
    op(tbl[0].dec, tbl[0].mp, tbl[0].t, tbl[0].s0, tbl[0].di, tbl[0].exw, 1'b1, 0, 1'b0, 0);

    // rst in DEC_IN after one word.
    tag_start = 1'b1; tag_dec = 1'b1; tag_mp = 3'd7; ccm_d = tbl[9].t;
    step();
    tag_start = 1'b0; ecb_do = tbl[9].s0; ecb_vld = 1'b1;
    step();
    ecb_vld = 1'b0; tag_di_vld = 1'b1; tag_di = 32'h01234567;
    step();
    rst = 1'b1; tag_di = 32'h89ABCDEF;
    step();
    rst = 1'b0;
    idle_inputs();
    chk_zero("abort_dec");
    step();
    chk("abort_dec_no_done", 128'(tag_done), 128'(0));

    for (int i = 0; i < 60; i++) begin
      dec = 1'($urandom);
      mp  = 3'($urandom);
      t   = r128();
      s0  = r128();
      u   = t ^ s0;
      di  = u;
      for (int j = 0; j < 16; j++) begin
        if ($urandom_range(0, 9) == 0) di[127-8*j -: 8] = di[127-8*j -: 8] ^ 8'($urandom_range(1, 255));
      end
      model(t, s0, mp, di, exw, okd);
      op(dec, mp, t, s0, di, exw, (mp == 3'd0) ? 1'b0 : (dec ? okd : 1'b1),
         $urandom_range(0, 3), 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
